// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoder halfword
// stream and branch redirect. master = fetch unit, slave = its environment.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        branch_en;
  logic [31:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, branch_en, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, branch_en, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Thumb fetch stage: word reads from imem, split into PC-tagged halfwords via a
// prefetch FIFO. Define FETCH_PERF_EN to add the fetch/flush performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] RESET_HPC  = {RESET_PC[31:1], 1'b0};

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] hw;
  } entry_t;

  state_t        state, state_nx;
  logic [31:0]   addr, addr_nx;
  logic [31:0]   tgt, tgt_nx;
  logic          skip_low, skip_low_nx;
  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   free_now, fill_after, br_word;
  logic          pop, push_lo, push_hi;
  entry_t        lo_entry, hi_entry;
  logic          unused_target_bit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign br_word           = {bus.branch_target[31:2], 2'b00};
  assign unused_target_bit = bus.branch_target[0];
  assign free_now          = FIFO_DEPTH - 32'(count);
  assign pop               = bus.instr_valid && bus.instr_ready;
  assign lo_entry          = '{pc: addr, hw: bus.imem_rdata[15:0]};
  assign hi_entry          = '{pc: {addr[31:2], 2'b10}, hw: bus.imem_rdata[31:16]};

  assign bus.imem_addr   = addr;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = mem[rd_ptr].hw;
  assign bus.instr_pc    = mem[rd_ptr].pc;

  // In DROP the bus keeps the old address; the redirect waits in tgt.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    tgt_nx       = tgt;
    skip_low_nx  = skip_low;
    push_lo      = 1'b0;
    push_hi      = 1'b0;
    fill_after   = '0;
    bus.imem_req = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.branch_en) begin
          addr_nx     = br_word;
          skip_low_nx = bus.branch_target[1];
          state_nx    = REQ;
        end else if (free_now >= 32'd2) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.branch_en) begin
          skip_low_nx = bus.branch_target[1];
          if (bus.imem_ack) begin
            addr_nx  = br_word;
            state_nx = REQ;
          end else begin
            tgt_nx   = br_word;
            state_nx = DROP;
          end
        end else if (bus.imem_ack) begin
          push_lo     = !skip_low;
          push_hi     = 1'b1;
          skip_low_nx = 1'b0;
          addr_nx     = addr + 32'd4;
          fill_after  = 32'(count) + (skip_low ? 32'd1 : 32'd2) - 32'(pop);
          state_nx    = (FIFO_DEPTH - fill_after >= 32'd2) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (bus.branch_en) begin
          tgt_nx      = br_word;
          skip_low_nx = bus.branch_target[1];
        end else if (bus.imem_ack) begin
          addr_nx  = tgt;
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= RESET_WORD;
      tgt      <= RESET_WORD;
      skip_low <= RESET_PC[1];
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '{pc: RESET_HPC, hw: 16'h0000};
      end
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      tgt      <= tgt_nx;
      skip_low <= skip_low_nx;
      if (bus.branch_en) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_lo && push_hi) begin
          mem[wr_ptr]          <= lo_entry;
          mem[ptr_inc(wr_ptr)] <= hi_entry;
          wr_ptr               <= ptr_inc(ptr_inc(wr_ptr));
        end else if (push_hi) begin
          mem[wr_ptr] <= hi_entry;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        count <= count + CW'(push_lo) + CW'(push_hi) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (state == REQ && bus.imem_ack) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (bus.branch_en) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif
endmodule
